// File: rtl/memory_interface_pkg.sv
// Shared definitions for the memory interface: bus widths and the
// transaction FSM state encoding.
package memory_interface_pkg;

  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    DONE
  } state_t;

endpackage

// File: rtl/memory_interface_if.sv
// Signal bundle between the CPU/RAM side and the memory interface block.
//   slave  : the memory_interface block (takes bus, strobes and RAM read data;
//            drives MDR, status and RAM address/strobes/write data)
//   master : the CPU/RAM environment driving the block
interface memory_interface_if;
  import memory_interface_pkg::*;

  logic [DATA_WIDTH-1:0] bus_in;
  logic                  MAR_in;
  logic                  MDR_in;
  logic                  read_req;
  logic                  write_req;
  logic [DATA_WIDTH-1:0] mdr_q;
  logic                  mem_busy;
  logic                  mem_done;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_read;
  logic                  ram_write;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic [DATA_WIDTH-1:0] ram_data_in;

  modport slave (
    input  bus_in, MAR_in, MDR_in, read_req, write_req, ram_data_in,
    output mdr_q, mem_busy, mem_done, ram_address, ram_read, ram_write,
           ram_data_out
  );

  modport master (
    output bus_in, MAR_in, MDR_in, read_req, write_req, ram_data_in,
    input  mdr_q, mem_busy, mem_done, ram_address, ram_read, ram_write,
           ram_data_out
  );

endinterface

// File: rtl/memory_interface_fsm.sv
// mem_fsm: transaction sequencer for the memory interface.
// Ports: clk, clear (async active-high), read_req/write_req in;
//        state plus Moore strobes ram_read, ram_write, mem_busy, mem_done out.
//
// state      | meaning
// IDLE       | waiting for a request; MAR/MDR loads allowed
// RD_ISSUE   | ram_read asserted, RAM samples address
// RD_CAPTURE | RAM data valid, MDR loads at the ending edge
// WR_ISSUE   | ram_write asserted, RAM commits at the ending edge
// DONE       | mem_done pulse, then back to IDLE
module mem_fsm
  import memory_interface_pkg::*;
(
  input  logic   clk,
  input  logic   clear,
  input  logic   read_req,
  input  logic   write_req,
  output state_t state,
  output logic   ram_read,
  output logic   ram_write,
  output logic   mem_busy,
  output logic   mem_done
);

  state_t state_nxt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    mem_done  = 1'b0;
    mem_busy  = (state != IDLE);
    case (state)
      IDLE: begin
        // write wins when both requests arrive together
        if (write_req)     state_nxt = WR_ISSUE;
        else if (read_req) state_nxt = RD_ISSUE;
      end
      RD_ISSUE: begin
        ram_read  = 1'b1;
        state_nxt = RD_CAPTURE;
      end
      RD_CAPTURE: state_nxt = DONE;
      WR_ISSUE: begin
        ram_write = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        mem_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/memory_interface.sv
// memory_interface: MAR/MDR register pair plus a single-port RAM sequencer.
// Ports: clk, clear (async active-high), mif (slave modport) carrying the
//        CPU bus, load strobes, requests, MDR/status outputs and RAM side.
module memory_interface
  import memory_interface_pkg::*;
(
  input  logic                clk,
  input  logic                clear,
  memory_interface_if.slave   mif
);

  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] mdr;
  state_t                state;

  mem_fsm u_fsm (
    .clk       (clk),
    .clear     (clear),
    .read_req  (mif.read_req),
    .write_req (mif.write_req),
    .state     (state),
    .ram_read  (mif.ram_read),
    .ram_write (mif.ram_write),
    .mem_busy  (mif.mem_busy),
    .mem_done  (mif.mem_done)
  );

  // Loads are gated by IDLE so the address and write data cannot move
  // under an in-flight transaction. A load in the same cycle as a request
  // lands at the edge that leaves IDLE, so the transaction sees it.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (state == IDLE && mif.MAR_in) mar <= mif.bus_in[ADDR_WIDTH-1:0];
      if (state == RD_CAPTURE)         mdr <= mif.ram_data_in;
      else if (state == IDLE && mif.MDR_in) mdr <= mif.bus_in;
    end
  end

  assign mif.mdr_q        = mdr;
  assign mif.ram_address  = mar;
  assign mif.ram_data_out = mdr;

endmodule

// File: tb/tb_memory_interface.sv
module tb_memory_interface;

  logic clk;
  logic clear;
  int   total;
  int   bad;

  memory_interface_if mif ();

  memory_interface dut (
    .clk   (clk),
    .clear (clear),
    .mif   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, read data valid the cycle after ram_read.
  logic [31:0] ram [0:511];
  logic [31:0] rdata;
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mif.ram_write) ram[mif.ram_address] <= mif.ram_data_out;
    if (mif.ram_read) rdata <= ram[mif.ram_address];
    else              rdata <= 32'hxxxx_xxxx;
  end
  assign mif.ram_data_in = rdata;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  task automatic load_mar(input logic [31:0] v);
    mif.bus_in = v;
    mif.MAR_in = 1'b1;
    step();
    mif.MAR_in = 1'b0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    mif.bus_in = v;
    mif.MDR_in = 1'b1;
    step();
    mif.MDR_in = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    step();
    step();
    total++;
    if ({mif.mem_busy, mif.mem_done, mif.ram_read, mif.ram_write} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_strobes: got %b want 0000",
               {mif.mem_busy, mif.mem_done, mif.ram_read, mif.ram_write});
    end
    total++;
    if (mif.ram_address !== 9'h000 || mif.mdr_q !== 32'h0) begin
      bad++;
      $display("FAIL reset_regs: mar=%h mdr=%h want 0/0", mif.ram_address, mif.mdr_q);
    end
    clear = 1'b0;
  endtask

  task automatic test_read();
    logic [3:0] exp_rd, exp_busy, exp_done;
    exp_rd   = 4'b0001;
    exp_busy = 4'b0111;
    exp_done = 4'b0100;
    preload(9'h012, 32'hDEADBEEF);
    load_mar(32'h0000_0012);
    total++;
    if (mif.ram_address !== 9'h012) begin
      bad++;
      $display("FAIL read_mar: got %h want 012", mif.ram_address);
    end
    mif.read_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      mif.read_req = 1'b0;
      total++;
      if ({mif.ram_read, mif.mem_busy, mif.mem_done} !== {exp_rd[i], exp_busy[i], exp_done[i]}) begin
        bad++;
        $display("FAIL read_seq[%0d]: rd/busy/done=%b want %b", i,
                 {mif.ram_read, mif.mem_busy, mif.mem_done},
                 {exp_rd[i], exp_busy[i], exp_done[i]});
      end
      if (i == 2) begin
        total++;
        if (mif.mdr_q !== 32'hDEADBEEF) begin
          bad++;
          $display("FAIL read_data: got %h want deadbeef", mif.mdr_q);
        end
      end
    end
  endtask

  task automatic test_write();
    logic [2:0] exp_wr, exp_busy, exp_done;
    exp_wr   = 3'b001;
    exp_busy = 3'b011;
    exp_done = 3'b010;
    load_mar(32'h0000_01FF);
    load_mdr(32'h12345678);
    mif.write_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      mif.write_req = 1'b0;
      total++;
      if ({mif.ram_write, mif.mem_busy, mif.mem_done} !== {exp_wr[i], exp_busy[i], exp_done[i]}) begin
        bad++;
        $display("FAIL write_seq[%0d]: wr/busy/done=%b want %b", i,
                 {mif.ram_write, mif.mem_busy, mif.mem_done},
                 {exp_wr[i], exp_busy[i], exp_done[i]});
      end
    end
    total++;
    if (ram[9'h1FF] !== 32'h12345678) begin
      bad++;
      $display("FAIL write_ram: got %h want 12345678", ram[9'h1FF]);
    end
    load_mdr(32'h0);
    mif.read_req = 1'b1;
    step();
    mif.read_req = 1'b0;
    step();
    step();
    total++;
    if (mif.mdr_q !== 32'h12345678 || mif.mem_done !== 1'b1) begin
      bad++;
      $display("FAIL write_readback: mdr=%h done=%b want 12345678/1", mif.mdr_q, mif.mem_done);
    end
    step();
  endtask

  task automatic test_priority();
    int rd_seen;
    rd_seen = 0;
    preload(9'h1A5, 32'h0);
    // same-cycle MAR/MDR load with both requests: bus_in[8:0] = 0x1A5
    mif.bus_in    = 32'hA5A5A5A5;
    mif.MAR_in    = 1'b1;
    mif.MDR_in    = 1'b1;
    mif.read_req  = 1'b1;
    mif.write_req = 1'b1;
    step();
    mif.MAR_in    = 1'b0;
    mif.MDR_in    = 1'b0;
    mif.read_req  = 1'b0;
    mif.write_req = 1'b0;
    total++;
    if (mif.ram_write !== 1'b1 || mif.ram_address !== 9'h1A5) begin
      bad++;
      $display("FAIL prio_issue: wr=%b addr=%h want 1/1a5", mif.ram_write, mif.ram_address);
    end
    for (int i = 0; i < 3; i++) begin
      if (mif.ram_read !== 1'b0) rd_seen++;
      step();
    end
    total++;
    if (rd_seen != 0) begin
      bad++;
      $display("FAIL prio_no_read: ram_read seen %0d cycles want 0", rd_seen);
    end
    total++;
    if (ram[9'h1A5] !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL prio_ram: got %h want a5a5a5a5", ram[9'h1A5]);
    end
  endtask

  task automatic test_mar_lock();
    preload(9'h050, 32'hCAFEF00D);
    preload(9'h044, 32'h44444444);
    load_mar(32'h0000_0050);
    mif.read_req = 1'b1;
    step();
    mif.read_req = 1'b0;
    step();
    mif.bus_in = 32'h0000_0044;
    mif.MAR_in = 1'b1;
    mif.MDR_in = 1'b1;
    step();
    mif.MAR_in = 1'b0;
    mif.MDR_in = 1'b0;
    total++;
    if (mif.ram_address !== 9'h050) begin
      bad++;
      $display("FAIL lock_mar: got %h want 050", mif.ram_address);
    end
    total++;
    if (mif.mdr_q !== 32'hCAFEF00D || mif.mem_done !== 1'b1) begin
      bad++;
      $display("FAIL lock_data: mdr=%h done=%b want cafef00d/1", mif.mdr_q, mif.mem_done);
    end
    step();
  endtask

  task automatic test_held_request();
    logic [4:0] exp_rd, exp_busy;
    exp_rd   = 5'b10001;
    exp_busy = 5'b10111;
    mif.read_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({mif.ram_read, mif.mem_busy} !== {exp_rd[i], exp_busy[i]}) begin
        bad++;
        $display("FAIL held_seq[%0d]: rd/busy=%b want %b", i,
                 {mif.ram_read, mif.mem_busy}, {exp_rd[i], exp_busy[i]});
      end
    end
    mif.read_req = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_clear_abort();
    int done_seen;
    done_seen = 0;
    preload(9'h0AA, 32'h11111111);
    load_mar(32'h0000_00AA);
    load_mdr(32'h77777777);
    mif.write_req = 1'b1;
    step();
    mif.write_req = 1'b0;
    total++;
    if (mif.ram_write !== 1'b1) begin
      bad++;
      $display("FAIL abort_issue: ram_write=%b want 1", mif.ram_write);
    end
    clear = 1'b1;
    #1;
    total++;
    if ({mif.ram_write, mif.mem_busy, mif.mem_done} !== 3'b000 ||
        mif.ram_address !== 9'h000 || mif.ram_data_out !== 32'h0) begin
      bad++;
      $display("FAIL abort_async: wr/busy/done=%b mar=%h mdr=%h want 000/0/0",
               {mif.ram_write, mif.mem_busy, mif.mem_done}, mif.ram_address, mif.ram_data_out);
    end
    step();
    if (mif.mem_done !== 1'b0) done_seen++;
    clear = 1'b0;
    mif.read_req = 1'b1;
    step();
    mif.read_req = 1'b0;
    total++;
    if ({mif.ram_read, mif.mem_busy} !== 2'b11) begin
      bad++;
      $display("FAIL abort_first_edge: rd/busy=%b want 11", {mif.ram_read, mif.mem_busy});
    end
    step();
    step();
    step();
    total++;
    if (done_seen != 0 || ram[9'h0AA] !== 32'h11111111) begin
      bad++;
      $display("FAIL abort_ram: done_seen=%0d ram=%h want 0/11111111", done_seen, ram[9'h0AA]);
    end
  endtask

  task automatic test_addr_trunc();
    load_mar(32'hFFFF_FE03);
    total++;
    if (mif.ram_address !== 9'h003) begin
      bad++;
      $display("FAIL addr_trunc: got %h want 003", mif.ram_address);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    pl_en         = 1'b0;
    pl_addr       = '0;
    pl_data       = '0;
    mif.bus_in    = '0;
    mif.MAR_in    = 1'b0;
    mif.MDR_in    = 1'b0;
    mif.read_req  = 1'b0;
    mif.write_req = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_priority();
    test_mar_lock();
    test_held_request();
    test_clear_abort();
    test_addr_trunc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
